// File: rtl/ysyx_25040129_axi_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_25040129_axi_arbiter
//
// Purpose
//   Merges the two core-side AXI4 masters onto the single SoC io_master port.
//     M0 = IFU : read-only, INCR bursts of m0_arlen+1 beats, 32-bit beats.
//     M1 = LSU : single-beat reads and single-beat writes.
//   At most one read and one write transaction are outstanding on io_master.
//   Reads are granted round-robin between M0 and M1. Writes come only from
//   M1 and pass through a small tracking FSM that lets AW and W handshake
//   independently.
//
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   m0_ar* / m0_r*          IFU read address / read data channels
//   m1_ar* / m1_r*          LSU read address / read data channels
//   m1_aw* / m1_w* / m1_b*  LSU write address / write data / response
//   io_master_*             downstream AXI4 master port (ids driven 0,
//                           returned rid/bid ignored)
// ---------------------------------------------------------------------------
module ysyx_25040129_axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                clock,
    input  logic                reset,

    // M0 (IFU) read address
    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [7:0]          m0_arlen,
    // M0 (IFU) read data
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rlast,

    // M1 (LSU) read address
    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [2:0]          m1_arsize,
    // M1 (LSU) read data
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    // M1 (LSU) write address
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [2:0]          m1_awsize,
    // M1 (LSU) write data
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    // M1 (LSU) write response
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [1:0]          m1_bresp,

    // io_master read address
    output logic                io_master_arvalid,
    input  logic                io_master_arready,
    output logic [ADDR_W-1:0]   io_master_araddr,
    output logic [ID_W-1:0]     io_master_arid,
    output logic [7:0]          io_master_arlen,
    output logic [2:0]          io_master_arsize,
    output logic [1:0]          io_master_arburst,
    // io_master read data
    input  logic                io_master_rvalid,
    output logic                io_master_rready,
    input  logic [DATA_W-1:0]   io_master_rdata,
    input  logic [1:0]          io_master_rresp,
    input  logic                io_master_rlast,
    input  logic [ID_W-1:0]     io_master_rid,
    // io_master write address
    output logic                io_master_awvalid,
    input  logic                io_master_awready,
    output logic [ADDR_W-1:0]   io_master_awaddr,
    output logic [ID_W-1:0]     io_master_awid,
    output logic [7:0]          io_master_awlen,
    output logic [2:0]          io_master_awsize,
    output logic [1:0]          io_master_awburst,
    // io_master write data
    output logic                io_master_wvalid,
    input  logic                io_master_wready,
    output logic [DATA_W-1:0]   io_master_wdata,
    output logic [DATA_W/8-1:0] io_master_wstrb,
    output logic                io_master_wlast,
    // io_master write response
    input  logic                io_master_bvalid,
    output logic                io_master_bready,
    input  logic [1:0]          io_master_bresp,
    input  logic [ID_W-1:0]     io_master_bid
);

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] IFU_SIZE   = 3'b010;
    localparam logic       GNT_M0     = 1'b0;
    localparam logic       GNT_M1     = 1'b1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    // Response IDs are not used: only one transaction per direction is ever
    // outstanding, so the response always belongs to the current owner.
    logic unused_ids;
    assign unused_ids = ^{io_master_rid, io_master_bid};

    // -----------------------------------------------------------------------
    // Read path
    // -----------------------------------------------------------------------
    r_state_e r_state_q, r_state_d;
    logic     grant_q, grant_d;
    logic     last_grant_q, last_grant_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q    <= R_IDLE;
            grant_q      <= GNT_M0;
            last_grant_q <= GNT_M0;
        end else begin
            r_state_q    <= r_state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        r_state_d         = r_state_q;
        grant_d           = grant_q;
        last_grant_d      = last_grant_q;
        io_master_arvalid = 1'b0;
        io_master_rready  = 1'b0;
        m0_arready        = 1'b0;
        m1_arready        = 1'b0;
        m0_rvalid         = 1'b0;
        m1_rvalid         = 1'b0;

        unique case (r_state_q)
            R_IDLE: begin
                // M1 wins when alone, or on a tie when M0 was served last.
                if (m0_arvalid || m1_arvalid) begin
                    grant_d      = (m1_arvalid && (!m0_arvalid || last_grant_q == GNT_M0))
                                   ? GNT_M1 : GNT_M0;
                    last_grant_d = grant_d;
                    r_state_d    = R_AR;
                end
            end
            R_AR: begin
                if (grant_q == GNT_M1) begin
                    io_master_arvalid = m1_arvalid;
                    m1_arready        = io_master_arready;
                end else begin
                    io_master_arvalid = m0_arvalid;
                    m0_arready        = io_master_arready;
                end
                if (io_master_arvalid && io_master_arready) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (grant_q == GNT_M1) begin
                    m1_rvalid        = io_master_rvalid;
                    io_master_rready = m1_rready;
                end else begin
                    m0_rvalid        = io_master_rvalid;
                    io_master_rready = m0_rready;
                end
                if (io_master_rvalid && io_master_rready && io_master_rlast) begin
                    r_state_d = R_IDLE;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // Address-channel payload follows the registered grant; it is only
    // meaningful while io_master_arvalid is high.
    always_comb begin
        io_master_arid    = '0;
        io_master_arburst = BURST_INCR;
        if (grant_q == GNT_M1) begin
            io_master_araddr = m1_araddr;
            io_master_arlen  = 8'd0;
            io_master_arsize = m1_arsize;
        end else begin
            io_master_araddr = m0_araddr;
            io_master_arlen  = m0_arlen;
            io_master_arsize = IFU_SIZE;
        end
    end

    // Read data payload is broadcast; only the rvalid above is steered.
    assign m0_rdata = io_master_rdata;
    assign m0_rresp = io_master_rresp;
    assign m0_rlast = io_master_rlast;
    assign m1_rdata = io_master_rdata;
    assign m1_rresp = io_master_rresp;

    // -----------------------------------------------------------------------
    // Write path (M1 only)
    // -----------------------------------------------------------------------
    w_state_e w_state_q, w_state_d;
    logic     aw_done_q, aw_done_d;
    logic     w_done_q, w_done_d;
    logic     aw_fire, w_fire;

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        w_state_d         = w_state_q;
        aw_done_d         = aw_done_q;
        w_done_d          = w_done_q;
        io_master_awvalid = 1'b0;
        io_master_wvalid  = 1'b0;
        io_master_bready  = 1'b0;
        m1_awready        = 1'b0;
        m1_wready         = 1'b0;
        m1_bvalid         = 1'b0;
        aw_fire           = 1'b0;
        w_fire            = 1'b0;

        unique case (w_state_q)
            W_IDLE: begin
                if (m1_awvalid) begin
                    w_state_d = W_REQ;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            W_REQ: begin
                // Each channel is masked once it has handshaken so the
                // slave never sees a second AW or W for this write.
                io_master_awvalid = m1_awvalid && !aw_done_q;
                io_master_wvalid  = m1_wvalid  && !w_done_q;
                m1_awready        = io_master_awready && !aw_done_q;
                m1_wready         = io_master_wready  && !w_done_q;
                aw_fire           = io_master_awvalid && io_master_awready;
                w_fire            = io_master_wvalid  && io_master_wready;
                if (aw_fire) aw_done_d = 1'b1;
                if (w_fire)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                m1_bvalid        = io_master_bvalid;
                io_master_bready = m1_bready;
                if (io_master_bvalid && io_master_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    assign io_master_awaddr  = m1_awaddr;
    assign io_master_awid    = '0;
    assign io_master_awlen   = 8'd0;
    assign io_master_awsize  = m1_awsize;
    assign io_master_awburst = BURST_INCR;
    assign io_master_wdata   = m1_wdata;
    assign io_master_wstrb   = m1_wstrb;
    assign io_master_wlast   = 1'b1;
    assign m1_bresp          = io_master_bresp;

endmodule

// File: tb/tb_ysyx_25040129_axi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25040129_axi_arbiter
//
// Drives the arbiter from two master models and a one-outstanding slave
// model. Inputs change on the falling edge; outputs are sampled 1 time unit
// before the rising edge, where the handshakes about to occur are scored.
// ---------------------------------------------------------------------------
module tb_ysyx_25040129_axi_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [AW-1:0] m0_araddr;
    logic [7:0] m0_arlen;
    logic [DW-1:0] m0_rdata;
    logic [1:0] m0_rresp;
    logic m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [AW-1:0] m1_araddr, m1_awaddr;
    logic [2:0] m1_arsize, m1_awsize;
    logic [DW-1:0] m1_rdata, m1_wdata;
    logic [1:0] m1_rresp, m1_bresp;
    logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [DW/8-1:0] m1_wstrb;
    logic io_master_arvalid, io_master_arready, io_master_rvalid, io_master_rready, io_master_rlast;
    logic [AW-1:0] io_master_araddr, io_master_awaddr;
    logic [IW-1:0] io_master_arid, io_master_rid, io_master_awid, io_master_bid;
    logic [7:0] io_master_arlen, io_master_awlen;
    logic [2:0] io_master_arsize, io_master_awsize;
    logic [1:0] io_master_arburst, io_master_awburst, io_master_rresp, io_master_bresp;
    logic [DW-1:0] io_master_rdata, io_master_wdata;
    logic io_master_awvalid, io_master_awready, io_master_wvalid, io_master_wready, io_master_wlast;
    logic [DW/8-1:0] io_master_wstrb;
    logic io_master_bvalid, io_master_bready;

    ysyx_25040129_axi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clock(clock), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arsize(m1_arsize),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awsize(m1_awsize),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
        .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
        .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid), .io_master_arlen(io_master_arlen),
        .io_master_arsize(io_master_arsize), .io_master_arburst(io_master_arburst),
        .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready), .io_master_rdata(io_master_rdata),
        .io_master_rresp(io_master_rresp), .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid),
        .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
        .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid), .io_master_awlen(io_master_awlen),
        .io_master_awsize(io_master_awsize), .io_master_awburst(io_master_awburst),
        .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready), .io_master_wdata(io_master_wdata),
        .io_master_wstrb(io_master_wstrb), .io_master_wlast(io_master_wlast),
        .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready), .io_master_bresp(io_master_bresp),
        .io_master_bid(io_master_bid)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Stimulus knobs
    bit rst_cmd = 1'b1, rnd = 1'b0, aw_block = 1'b0, w_block = 1'b0;
    // Master intent
    bit m0_req, m1r_req, m1aw_req, m1w_req;
    logic [31:0] m0_addr, m1r_addr, m1_waddr, m1_wdat;
    logic [7:0]  m0_len;
    logic [2:0]  m1r_size, m1_wsize;
    logic [3:0]  m1_wstb;
    // Master-side scoreboard
    bit m0_active, m1_active;
    int m0_idx;
    logic [31:0] m0_cur_addr, m1_cur_addr;
    logic [7:0]  m0_cur_len;
    int m0_bursts, m0_beats, m1_reads, m1_writes, aw_cnt, w_cnt;
    int m0_last_cyc, m1_ar_cyc, aw_cyc, w_cyc;
    int grant_log[$];
    // Slave model
    bit rq_valid, rv_hold, bv_hold, s_aw_got, s_w_got;
    logic [31:0] rq_addr, s_awaddr;
    logic [7:0]  rq_len;
    int rq_idx;

    function automatic logic [31:0] rdat(input logic [31:0] a, input int i);
        return (a + 32'(i) * 32'd4) ^ 32'h5a5a_0000;
    endfunction
    function automatic logic [1:0] rrsp(input logic [31:0] a, input int i);
        return 2'(a[5:4] + 2'(i));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] vr_outs();
        return {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid,
                io_master_arvalid, io_master_rready, io_master_awvalid, io_master_wvalid, io_master_bready};
    endfunction

    task automatic clear_model();
        m0_req = 0; m1r_req = 0; m1aw_req = 0; m1w_req = 0;
        m0_active = 0; m1_active = 0;
        rq_valid = 0; rv_hold = 0; bv_hold = 0; s_aw_got = 0; s_w_got = 0;
    endtask

    task automatic observe();
        // Routing that the model can predict every cycle
        check("m0_rvalid_route", m0_rvalid, io_master_rvalid && m0_active);
        check("m1_rvalid_route", m1_rvalid, io_master_rvalid && m1_active);
        check("rready_route", io_master_rready, m0_active ? m0_rready : (m1_active ? m1_rready : 1'b0));
        check("bvalid_route", m1_bvalid, io_master_bvalid);
        check("bready_route", io_master_bready, (s_aw_got && s_w_got) ? m1_bready : 1'b0);

        if (io_master_rvalid && io_master_rready) begin
            if (m0_active) begin
                check("m0_rdata", m0_rdata, rdat(m0_cur_addr, m0_idx));
                check("m0_rresp", m0_rresp, rrsp(m0_cur_addr, m0_idx));
                check("m0_rlast", m0_rlast, m0_idx == int'(m0_cur_len));
                m0_beats++;
                if (m0_idx == int'(m0_cur_len)) begin
                    m0_active = 0; m0_bursts++; m0_last_cyc = cyc;
                end
                m0_idx++;
            end else if (m1_active) begin
                check("m1_rdata", m1_rdata, rdat(m1_cur_addr, 0));
                check("m1_rresp", m1_rresp, rrsp(m1_cur_addr, 0));
                m1_active = 0; m1_reads++;
            end else begin
                check("r_unowned", io_master_rready, 1'b0);
            end
            rq_idx++; rv_hold = 0;
            if (rq_idx > int'(rq_len)) rq_valid = 0;
        end else if (io_master_rvalid) begin
            rv_hold = 1;
        end

        if (io_master_arvalid && io_master_arready) begin
            check("ar_single_outstanding", rq_valid, 1'b0);
            check("ar_burst", io_master_arburst, 2'b01);
            check("ar_id", io_master_arid, 4'd0);
            check("ar_one_grant", m0_arready ^ m1_arready, 1'b1);
            if (m0_arready) begin
                check("m0_ar_pending", m0_req, 1'b1);
                check("m0_araddr", io_master_araddr, m0_addr);
                check("m0_arlen", io_master_arlen, m0_len);
                check("m0_arsize", io_master_arsize, 3'b010);
                m0_req = 0; m0_active = 1; m0_idx = 0;
                m0_cur_addr = m0_addr; m0_cur_len = m0_len;
                grant_log.push_back(0);
            end else if (m1_arready) begin
                check("m1_ar_pending", m1r_req, 1'b1);
                check("m1_araddr", io_master_araddr, m1r_addr);
                check("m1_arlen", io_master_arlen, 8'd0);
                check("m1_arsize", io_master_arsize, m1r_size);
                m1r_req = 0; m1_active = 1; m1_cur_addr = m1r_addr; m1_ar_cyc = cyc;
                grant_log.push_back(1);
            end
            rq_valid = 1; rq_addr = io_master_araddr; rq_len = io_master_arlen; rq_idx = 0; rv_hold = 0;
        end else begin
            check("m0_ar_phantom", m0_arvalid && m0_arready, 1'b0);
            check("m1_ar_phantom", m1_arvalid && m1_arready, 1'b0);
        end

        if (io_master_awvalid && io_master_awready) begin
            check("aw_once", s_aw_got, 1'b0);
            check("m1_awready", m1_awready, 1'b1);
            check("aw_pending", m1aw_req, 1'b1);
            check("awaddr", io_master_awaddr, m1_waddr);
            check("awsize", io_master_awsize, m1_wsize);
            check("awlen_burst_id", {io_master_awlen, io_master_awburst, io_master_awid}, {8'd0, 2'b01, 4'd0});
            s_aw_got = 1; s_awaddr = io_master_awaddr; m1aw_req = 0; aw_cyc = cyc; aw_cnt++;
        end else begin
            check("aw_phantom", m1_awvalid && m1_awready, 1'b0);
        end

        if (io_master_wvalid && io_master_wready) begin
            check("w_once", s_w_got, 1'b0);
            check("m1_wready", m1_wready, 1'b1);
            check("w_pending", m1w_req, 1'b1);
            check("wdata", io_master_wdata, m1_wdat);
            check("wstrb_wlast", {io_master_wstrb, io_master_wlast}, {m1_wstb, 1'b1});
            s_w_got = 1; m1w_req = 0; w_cyc = cyc; w_cnt++;
        end else begin
            check("w_phantom", m1_wvalid && m1_wready, 1'b0);
        end

        if (io_master_bvalid && io_master_bready) begin
            check("m1_bresp", m1_bresp, m1_waddr[4:3]);
            s_aw_got = 0; s_w_got = 0; bv_hold = 0; m1_writes++;
        end else if (io_master_bvalid) begin
            bv_hold = 1;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
        reset      = rst_cmd;
        m0_arvalid = m0_req;   m0_araddr = m0_addr;  m0_arlen  = m0_len;
        m1_arvalid = m1r_req;  m1_araddr = m1r_addr; m1_arsize = m1r_size;
        m1_awvalid = m1aw_req; m1_awaddr = m1_waddr; m1_awsize = m1_wsize;
        m1_wvalid  = m1w_req;  m1_wdata  = m1_wdat;  m1_wstrb  = m1_wstb;
        m0_rready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        m1_rready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        m1_bready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        io_master_arready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
        io_master_awready = aw_block ? 1'b0 : (rnd ? ($urandom_range(0, 1) != 0) : 1'b1);
        io_master_wready  = w_block  ? 1'b0 : (rnd ? ($urandom_range(0, 1) != 0) : 1'b1);
        io_master_rvalid  = rq_valid && (rv_hold || !rnd || ($urandom_range(0, 2) != 0));
        io_master_rdata   = rq_valid ? rdat(rq_addr, rq_idx) : $urandom;
        io_master_rresp   = rrsp(rq_addr, rq_idx);
        io_master_rlast   = rq_valid && (rq_idx == int'(rq_len));
        io_master_rid     = 4'($urandom);
        io_master_bvalid  = s_aw_got && s_w_got && (bv_hold || !rnd || ($urandom_range(0, 1) != 0));
        io_master_bresp   = s_awaddr[4:3];
        io_master_bid     = 4'($urandom);
        #4;
        if (reset) clear_model();
        else observe();
    endtask

    initial begin
        int n0, n1, nw, base;
        m0_addr = 0; m0_len = 0; m1r_addr = 0; m1r_size = 3'd2;
        m1_waddr = 0; m1_wdat = 0; m1_wsize = 3'd2; m1_wstb = 0;
        rq_addr = 0; rq_len = 0; rq_idx = 0; s_awaddr = 0;
        clear_model();
        m0_arvalid = 0; m1_arvalid = 0; m1_awvalid = 0; m1_wvalid = 0;
        m0_rready = 0; m1_rready = 0; m1_bready = 0;
        io_master_arready = 0; io_master_awready = 0; io_master_wready = 0;
        io_master_rvalid = 0; io_master_bvalid = 0;
        repeat (3) tick();
        rst_cmd = 0;
        tick();
        check("reset_outputs_zero", vr_outs(), 12'd0);

        // 1: M0 alone, 4-beat burst, one-cycle request latency
        m0_addr = 32'h3000_0000; m0_len = 8'd3; m0_req = 1;
        tick();
        check("t1_idle_no_forward", io_master_arvalid, 1'b0);
        tick();
        check("t1_arvalid_latency", io_master_arvalid, 1'b1);
        for (int c = 0; c < 100 && m0_bursts == 0; c++) tick();
        check("t1_burst_done", m0_bursts, 1);
        check("t1_beats", m0_beats, 4);
        check("t1_no_m1_read", m1_reads, 0);
        tick();
        check("t1_back_idle", {io_master_arvalid, io_master_rready}, 2'b00);

        // 2: tied requests alternate starting with M1
        rnd = 1; base = grant_log.size();
        for (int r = 0; r < 10; r++) begin
            n0 = m0_bursts; n1 = m1_reads;
            m0_addr = 32'h3000_1000 + 32'(r) * 32'h40; m0_len = 8'($urandom_range(0, 3)); m0_req = 1;
            m1r_addr = 32'h8000_0100 + 32'(r) * 32'd4; m1r_size = 3'($urandom_range(0, 2)); m1r_req = 1;
            for (int c = 0; c < 500 && !(m0_bursts == n0 + 1 && m1_reads == n1 + 1); c++) tick();
            check("t2_round_done", {m0_bursts == n0 + 1, m1_reads == n1 + 1}, 2'b11);
        end
        check("t2_grants", grant_log.size() - base, 20);
        for (int i = 0; i < 20 && base + i < grant_log.size(); i++)
            check("t2_alternate", grant_log[base + i], (i % 2 == 0) ? 1 : 0);

        // 3: one M1 write in three AW/W orderings
        rnd = 0; m1_waddr = 32'ha000_03f8; m1_wdat = 32'hdeadbeef; m1_wstb = 4'b0011; m1_wsize = 3'd2;
        for (int k = 0; k < 3; k++) begin
            nw = m1_writes;
            aw_block = (k == 1); w_block = (k == 0);
            m1aw_req = 1; m1w_req = 1;
            for (int c = 0; c < 50 && !(s_aw_got || s_w_got); c++) tick();
            repeat (3) tick();
            aw_block = 0; w_block = 0;
            for (int c = 0; c < 100 && m1_writes == nw; c++) tick();
            check("t3_write_done", m1_writes, nw + 1);
            if (k == 0) check("t3_aw_first", aw_cyc < w_cyc, 1'b1);
            if (k == 1) check("t3_w_first", w_cyc < aw_cyc, 1'b1);
            if (k == 2) check("t3_same_cycle", aw_cyc == w_cyc, 1'b1);
        end
        check("t3_one_aw_one_w", {aw_cnt, w_cnt}, {m1_writes, m1_writes});

        // 4: write in flight alongside an M0 burst
        rnd = 1; n0 = m0_bursts; nw = m1_writes;
        m1_waddr = 32'ha000_0010; m1_wdat = $urandom; m1_wstb = 4'($urandom); m1aw_req = 1; m1w_req = 1;
        m0_addr = 32'h3000_2000; m0_len = 8'd5; m0_req = 1;
        for (int c = 0; c < 500 && !(m0_bursts == n0 + 1 && m1_writes == nw + 1); c++) tick();
        check("t4_both_done", {m0_bursts == n0 + 1, m1_writes == nw + 1}, 2'b11);

        // 5: M1 arrives mid-burst and waits for the last M0 beat
        n0 = m0_bursts; n1 = m1_reads;
        m0_addr = 32'h3000_3000; m0_len = 8'd7; m0_req = 1;
        for (int c = 0; c < 200 && !(m0_active && m0_idx >= 2); c++) tick();
        base = grant_log.size();
        m1r_addr = 32'h8000_0200; m1r_size = 3'd2; m1r_req = 1;
        for (int c = 0; c < 500 && !(m0_bursts == n0 + 1 && m1_reads == n1 + 1); c++) tick();
        check("t5_both_done", {m0_bursts == n0 + 1, m1_reads == n1 + 1}, 2'b11);
        check("t5_m1_after_rlast", m1_ar_cyc > m0_last_cyc, 1'b1);
        check("t5_m1_next_grant", (grant_log.size() > base) ? grant_log[base] : -1, 1);

        // 6: reset with a read in R_DATA and a write stuck in W_REQ
        aw_block = 1; w_block = 1;
        m1_waddr = 32'ha000_0020; m1aw_req = 1; m1w_req = 1;
        m0_addr = 32'h3000_4000; m0_len = 8'd7; m0_req = 1;
        for (int c = 0; c < 200 && !(m0_active && m0_idx >= 2); c++) tick();
        check("t6_in_data", m0_active, 1'b1);
        rst_cmd = 1;
        tick();
        rst_cmd = 0; aw_block = 0; w_block = 0;
        n0 = m0_bursts; nw = m1_writes;
        m0_addr = 32'h3000_5000; m0_len = 8'd2; m0_req = 1; m1aw_req = 1; m1w_req = 1;
        tick();
        check("t6_reset_outputs_zero", vr_outs(), 12'd0);
        for (int c = 0; c < 300 && !(m0_bursts == n0 + 1 && m1_writes == nw + 1); c++) tick();
        check("t6_fresh_traffic", {m0_bursts == n0 + 1, m1_writes == nw + 1}, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
